// File: rtl/pc_unit.sv
// pc_unit: program counter with prioritized redirects and an optional
// return-address stack. The RAS is built only when PC_UNIT_RAS_EN is
// defined; otherwise call is ignored, ret falls through to Address+4 and
// the RAS status outputs are tied to their empty values.
module pc_unit #(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] RESET_VEC = AW'(32'h0000_3000),
  parameter logic [AW-1:0] EXC_VEC   = AW'(32'h0000_4180),
  parameter int            NSTALL    = 2,
  parameter int            RAS_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NSTALL-1:0] stall,
  input  logic              br_taken,
  input  logic [AW-1:0]     br_target,
  input  logic              jmp,
  input  logic [AW-1:0]     jmp_target,
  input  logic              call,
  input  logic              jr,
  input  logic [AW-1:0]     jr_target,
  input  logic              ret,
  input  logic              exc,
  output logic [AW-1:0]     Address,
  output logic [AW-1:0]     Address_plus4,
  output logic              misalign,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_uflow
);

  logic          stalled;
  logic          ras_valid;   // ret has a stacked target available
  logic [AW-1:0] ras_top;
  logic [AW-1:0] nxt_pc;
  logic          nxt_mis;

  assign stalled       = |stall;
  assign Address_plus4 = Address + AW'(4);

`ifdef PC_UNIT_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [AW-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0] top;        // next push slot; oldest entry when full
  logic [PW-1:0] top_m1;
  logic [PW:0]   cnt;
  logic          push_en;
  logic          pop_en;

  // exc discards call/ret; jr outranks ret but still allows call
  assign push_en   = call & ~exc & ~stalled;
  assign pop_en    = ret & ~jr & ~exc & ~stalled;
  assign top_m1    = top - PW'(1);
  assign ras_top   = ras_mem[top_m1];
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == (PW+1)'(RAS_DEPTH));
  assign ras_valid = ~ras_empty;

  // RAS pointer/occupancy and underflow pulse
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      top       <= '0;
      cnt       <= '0;
      ras_uflow <= 1'b0;
    end else begin
      ras_uflow <= pop_en & ras_empty;
      if (pop_en && push_en) begin
        // pop-then-push replaces the top in place; empty stack just gains one
        if (ras_empty) begin
          top <= top + PW'(1);
          cnt <= (PW+1)'(1);
        end
      end else if (pop_en) begin
        if (!ras_empty) begin
          top <= top_m1;
          cnt <= cnt - (PW+1)'(1);
        end
      end else if (push_en) begin
        top <= top + PW'(1);
        if (!ras_full) cnt <= cnt + (PW+1)'(1);
      end
    end
  end

  // RAS storage write; a combined pop+push reuses the popped slot
  always_ff @(posedge Clk) begin
    if (push_en) begin
      if (pop_en && !ras_empty) ras_mem[top_m1] <= Address_plus4;
      else                      ras_mem[top]    <= Address_plus4;
    end
  end
`else
  logic unused_call;
  assign unused_call = call;
  assign ras_valid   = 1'b0;
  assign ras_top     = '0;
  assign ras_empty   = 1'b1;
  assign ras_full    = 1'b0;
  assign ras_uflow   = 1'b0;
`endif

  // next-PC select: exc > jr > ret > jmp > br_taken > Address+4
  always_comb begin
    nxt_pc  = Address_plus4;
    nxt_mis = 1'b0;
    if (exc) begin
      nxt_pc = EXC_VEC;
    end else if (jr) begin
      nxt_pc  = {jr_target[AW-1:2], 2'b00};
      nxt_mis = |jr_target[1:0];
    end else if (ret) begin
      if (ras_valid) begin
        nxt_pc  = {ras_top[AW-1:2], 2'b00};
        nxt_mis = |ras_top[1:0];
      end
    end else if (jmp) begin
      nxt_pc  = {jmp_target[AW-1:2], 2'b00};
      nxt_mis = |jmp_target[1:0];
    end else if (br_taken) begin
      nxt_pc  = {br_target[AW-1:2], 2'b00};
      nxt_mis = |br_target[1:0];
    end
  end

  // PC and misalign register; exc overrides stall
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Address  <= RESET_VEC;
      misalign <= 1'b0;
    end else if (exc || !stalled) begin
      Address  <= nxt_pc;
      misalign <= nxt_mis;
    end
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL parameter AW, default 32, program-counter width in bits (AW >= 8).
REQ-002 SHALL parameter RESET_VEC, default 32'h0000_3000 truncated to AW, Address value after reset.
REQ-003 SHALL parameter EXC_VEC, default 32'h0000_4180 truncated to AW, exception entry address.
REQ-004 SHALL parameter NSTALL, default 2, number of independent stall sources.
REQ-005 SHALL parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-006 SHALL port Clk  in  1  clock; all state updates on its rising edge.
REQ-007 SHALL port Reset  in  1  reset, asynchronous, active-low.
REQ-008 SHALL port stall  in  NSTALL  any bit high freezes PC (OR-reduced).
REQ-009 SHALL port br_taken / br_target  in  1 / AW  conditional branch redirect.
REQ-010 SHALL port jmp / jmp_target  in  1 / AW  unconditional jump; call  in  1  push return address.
REQ-011 SHALL port jr / jr_target  in  1 / AW  register-indirect jump; ret  in  1  pop RAS as target.
REQ-012 SHALL port exc  in  1  exception request.
REQ-013 SHALL port Address  out  AW  current PC (registered); Address_plus4  out  AW  Address+4 (combinational).
REQ-014 SHALL port misalign  out  1  registered flag: last loaded redirect target had bits [1:0] != 0.
REQ-015 SHALL port ras_empty / ras_full  out  1 / 1  RAS occupancy; ras_uflow  out  1  one-cycle pulse on pop of empty RAS.

Function
REQ-016 SHALL compute next-PC priority: exc > jr > ret > jmp > br_taken > Address+4.
REQ-017 SHALL load Address with next-PC on every rising edge when no stall bit is set; one-cycle latency from redirect input to Address.
REQ-018 SHALL hold Address, misalign and RAS state unchanged while any stall bit is set, except exc.
REQ-019 SHALL load EXC_VEC when exc is high regardless of stall; exc also discards simultaneous call/ret.
REQ-020 SHALL force target bits [1:0] to zero when loading any redirect target and set misalign if original bits were nonzero; sequential and EXC_VEC loads clear misalign.
REQ-021 SHALL wrap Address+4 modulo 2^AW (all-ones region rolls to 0, no flag).
REQ-022 SHALL, on accepted call (with jmp or jr as target source), push Address+4 onto RAS.
REQ-023 SHALL, on push when full, overwrite the oldest entry (circular), occupancy stays RAS_DEPTH, ras_full stays 1.
REQ-024 SHALL, on accepted ret with RAS non-empty, load Address with top entry and pop it.
REQ-025 SHALL, on accepted ret with RAS empty, load Address+4, leave RAS empty and pulse ras_uflow for one cycle.
REQ-026 SHALL treat simultaneous call and ret as ret-then-push: target = popped top (or Address+4 if empty), then Address+4 pushed; occupancy unchanged unless empty (then 1).
REQ-027 SHALL ignore call/ret when a higher-priority jr or exc selects the target, except call with jr (REQ-022).

Reset
REQ-028 SHALL on Reset low, immediately and independent of Clk and stall, set Address=RESET_VEC, misalign=0, ras_uflow=0, RAS occupancy 0 (ras_empty=1, ras_full=0).
REQ-029 SHALL resume with first update on the first rising edge after Reset deasserts; reset mid-redirect discards the redirect.

Configuration
REQ-030 SHALL with macro PC_UNIT_RAS_EN defined, implement RAS per REQ-022..REQ-026.
REQ-031 SHALL without PC_UNIT_RAS_EN, omit RAS storage; call ignored, ret treated as Address+4 with no ras_uflow pulse, ras_empty tied 1, ras_full tied 0, ras_uflow tied 0.

Verification
REQ-032 SHALL test reset: Reset low mid-cycle with Address=0x3010 -> Address=0x3000 immediately; 3 free cycles after release -> 0x3004, 0x3008, 0x300C.
REQ-033 SHALL test stall: stall=2'b10 for 2 cycles at 0x3008 -> Address stays 0x3008; then exc with stall=2'b11 -> Address=0x4180 next edge.
REQ-034 SHALL test priority: jr=1 target 0x5000, jmp=1 target 0x6000, br_taken=1 same cycle -> Address=0x5000; jmp_target 0x6002 alone -> 0x6000, misalign=1.
REQ-035 SHALL test RAS (PC_UNIT_RAS_EN, depth 4): 5 calls from 0x3000,0x3100,0x3200,0x3300,0x3400 -> ras_full=1; 4 rets -> 0x3404,0x3304,0x3204,0x3104; 5th ret -> Address+4, ras_uflow pulse, ras_empty=1.
REQ-036 SHALL test wrap: AW=32, Address=0xFFFF_FFFC, no redirect -> Address=0x0000_0000.
REQ-037 SHALL test build without PC_UNIT_RAS_EN: call+jmp to 0x7000 then ret -> Address=0x7004, ras_uflow stays 0.
